vga_text_line: RTL

- Overlays a horizontal string of N_CHARS 8x8 glyphs on the 26-bit RGB pixel stream.
- Adds a writable character buffer, power-of-two zoom, foreground/background colours, a transparent mode and a frame-counted blink.
- Sits in the stream chain between the VGA sync generator and the output stage. Several instances may be cascaded, one per text line.
- Stream layout: bit0 Active, bit1 VS, bit2 HS, [12:3] YC, [22:13] XC, [25:23] RGB (B,G,R).

---
 rtl/vga_text_line.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vga_text_line.sv
// rtl/vga_text_line.sv - overlays a zoomable line of 8x8 glyphs on the 26-bit RGB pixel stream
// Three-stage pipeline: box/index math, buffer + font read, pixel select.
module vga_text_font (
  input  logic        px_clk,
  input  logic        reset,
  input  logic [10:0] addr,
  output logic [7:0]  dout
);

  logic [7:0] code;
  logic [2:0] row;
  logic [7:0] glyph_row;

  assign code = addr[10:3];
  assign row  = addr[2:0];

  // CP437 block-graphics characters; every other code renders blank.
  always_comb begin
    glyph_row = 8'h00;
    case (code)
      8'hB0:   glyph_row = row[0] ? 8'h88 : 8'h22;
      8'hB1:   glyph_row = row[0] ? 8'hAA : 8'h55;
      8'hB2:   glyph_row = row[0] ? 8'hEE : 8'hBB;
      8'hDB:   glyph_row = 8'hFF;
      8'hDC:   glyph_row = row[2] ? 8'hFF : 8'h00;
      8'hDD:   glyph_row = 8'hF0;
      8'hDE:   glyph_row = 8'h0F;
      8'hDF:   glyph_row = row[2] ? 8'h00 : 8'hFF;
      default: glyph_row = 8'h00;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (reset) dout <= 8'h00;
    else       dout <= glyph_row;
  end

endmodule

module vga_text_line #(
  parameter int N_CHARS   = 16,
  parameter int ADDR_W    = 4,
  parameter int BLINK_BIT = 4
) (
  input  logic              px_clk,
  input  logic              reset,
  input  logic [25:0]       strRGB_i,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  input  logic [2:0]        zoom,
  input  logic [2:0]        fg_color,
  input  logic [2:0]        bg_color,
  input  logic              transparent,
  input  logic              blink_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [25:0]       strRGB_o
);

  localparam int EW = 24;
  localparam int BOX_W = N_CHARS * 8;
  localparam logic [ADDR_W:0] N_LIM = (ADDR_W + 1)'(N_CHARS);

  logic [9:0]    xc, yc;
  logic [13:0]   dx, dy, idx_full;
  logic [EW-1:0] x_end, y_end;
  logic          in_box_c;

  assign xc = strRGB_i[22:13];
  assign yc = strRGB_i[12:3];
  assign dx = 14'(xc) - 14'(x_pos);
  assign dy = 14'(yc) - 14'(y_pos);
  // Wide bounds so boxes reaching past 1023 clip instead of wrapping.
  assign x_end = EW'(x_pos) + (EW'(BOX_W) << zoom);
  assign y_end = EW'(y_pos) + (EW'(8) << zoom);
  assign in_box_c = (xc >= x_pos) && (EW'(xc) < x_end) &&
                    (yc >= y_pos) && (EW'(yc) < y_end);
  assign idx_full = dx >> (4'(zoom) + 4'd3);

  // Stage 1 registers
  logic [25:0]       s1_strm;
  logic              s1_in_box, s1_vs_d;
  logic [ADDR_W-1:0] s1_idx;
  logic [2:0]        s1_row, s1_col, s1_fg, s1_bg;
  logic              s1_transp, s1_blink_en;

  always_ff @(posedge px_clk) begin
    if (reset) begin
      s1_strm     <= '0;
      s1_in_box   <= 1'b0;
      s1_vs_d     <= 1'b0;
      s1_idx      <= '0;
      s1_row      <= '0;
      s1_col      <= '0;
      s1_fg       <= '0;
      s1_bg       <= '0;
      s1_transp   <= 1'b0;
      s1_blink_en <= 1'b0;
    end else begin
      s1_strm     <= strRGB_i;
      s1_in_box   <= in_box_c;
      s1_vs_d     <= s1_strm[1];
      s1_idx      <= ADDR_W'(idx_full);
      s1_row      <= 3'(dy >> zoom);
      s1_col      <= 3'(dx >> zoom);
      s1_fg       <= fg_color;
      s1_bg       <= bg_color;
      s1_transp   <= transparent;
      s1_blink_en <= blink_en;
    end
  end

  logic [7:0] frame_cnt;
  logic       blink_phase;

  always_ff @(posedge px_clk) begin
    if (reset)                      frame_cnt <= 8'd0;
    else if (s1_strm[1] && !s1_vs_d) frame_cnt <= frame_cnt + 8'd1;
  end

  assign blink_phase = frame_cnt[BLINK_BIT];

  // Character buffer: the stage-2 read sees the value before a same-cycle write.
  logic [7:0] char_buf [N_CHARS];

  always_ff @(posedge px_clk) begin
    if (reset) begin
      for (int i = 0; i < N_CHARS; i++) char_buf[i] <= 8'h20;
    end else if (wr_en && ({1'b0, wr_addr} < N_LIM)) begin
      char_buf[wr_addr] <= wr_data;
    end
  end

  logic [7:0] code;
  logic [7:0] rom_dout;

  assign code = ({1'b0, s1_idx} < N_LIM) ? char_buf[s1_idx] : 8'h20;

  vga_text_font u_font (
    .px_clk (px_clk),
    .reset  (reset),
    .addr   ({code, s1_row}),
    .dout   (rom_dout)
  );

  // Stage 2 registers travel alongside the font read
  logic [25:0] s2_strm;
  logic        s2_in_box, s2_transp, s2_blink_en;
  logic [2:0]  s2_col, s2_fg, s2_bg;

  always_ff @(posedge px_clk) begin
    if (reset) begin
      s2_strm     <= '0;
      s2_in_box   <= 1'b0;
      s2_transp   <= 1'b0;
      s2_blink_en <= 1'b0;
      s2_col      <= '0;
      s2_fg       <= '0;
      s2_bg       <= '0;
    end else begin
      s2_strm     <= s1_strm;
      s2_in_box   <= s1_in_box;
      s2_transp   <= s1_transp;
      s2_blink_en <= s1_blink_en;
      s2_col      <= s1_col;
      s2_fg       <= s1_fg;
      s2_bg       <= s1_bg;
    end
  end

  logic       pix, fg_on;
  logic [2:0] out_rgb;

  always_comb begin
    pix     = rom_dout[3'd7 - s2_col];
    fg_on   = pix && !(s2_blink_en && blink_phase);
    out_rgb = s2_strm[25:23];
    if (s2_strm[0] && s2_in_box) begin
      if (fg_on)           out_rgb = s2_fg;
      else if (!s2_transp) out_rgb = s2_bg;
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) strRGB_o <= '0;
    else       strRGB_o <= {out_rgb, s2_strm[22:0]};
  end

endmodule
